// File: rtl/fc_layer_seq.sv
// fc_layer_seq: sequencer around a combinational fully-connected neuron array.
//   LOAD   : streams IN activations into the x_vec register file.
//   SETTLE : holds x_vec for SETTLE cycles, then captures all NOUT results.
//   DRAIN  : emits the NOUT captured results one per beat (valid/ready).
// Ports:
//   clk, rst_n (async, active low), clear (sync abort)
//   in_valid/in_ready/in_data        activation stream
//   x_vec                            registered vector to the neuron array
//   z_vec                            neuron array results
//   out_valid/out_ready/out_data/out_idx/out_last  result stream
//   busy                             high unless idle in LOAD with nothing written
// Optional build macro: FC_SEQ_REQUANT_EN -- clip each result to 0..2^WIDTH-1.
module fc_layer_seq #(
  parameter int WIDTH  = 8,
  parameter int IN     = 128,
  parameter int NOUT   = 10,
  parameter int OW     = 23,
  parameter int SETTLE = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic [WIDTH*IN-1:0]      x_vec,
  input  logic [OW*NOUT-1:0]       z_vec,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OW-1:0]            out_data,
  output logic [$clog2(NOUT)-1:0]  out_idx,
  output logic                     out_last,
  output logic                     busy
);
  localparam int CW  = (IN > 1) ? $clog2(IN) : 1;
  localparam int IXW = $clog2(NOUT);

  typedef enum logic [1:0] {S_LOAD, S_SETTLE, S_DRAIN} state_t;

  state_t                     r_state;
  logic [CW-1:0]              r_wr_cnt;
  logic [3:0]                 r_settle_cnt;
  logic [IXW-1:0]             r_rd_idx;
  logic [IN-1:0][WIDTH-1:0]   r_x;
  logic [NOUT-1:0][OW-1:0]    r_res;
  logic                       r_in_ready;
  logic                       r_out_valid;
  logic [OW-1:0]              w_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_LOAD;
      r_wr_cnt     <= '0;
      r_settle_cnt <= '0;
      r_rd_idx     <= '0;
      r_x          <= '0;
      r_res        <= '0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
    end else if (clear) begin
      // Abort wins over any handshake this cycle; x_vec is left as is.
      r_state      <= S_LOAD;
      r_wr_cnt     <= '0;
      r_settle_cnt <= '0;
      r_rd_idx     <= '0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (in_valid && r_in_ready) begin
            r_x[r_wr_cnt] <= in_data;
            if (r_wr_cnt == CW'(IN-1)) begin
              r_wr_cnt     <= '0;
              r_settle_cnt <= 4'(SETTLE);
              r_in_ready   <= 1'b0;
              r_state      <= S_SETTLE;
            end else begin
              r_wr_cnt <= r_wr_cnt + 1'b1;
            end
          end
        end
        S_SETTLE: begin
          r_settle_cnt <= r_settle_cnt - 1'b1;
          // Last settle cycle: the array output is stable, take a snapshot.
          if (r_settle_cnt == 4'd1) begin
            r_res       <= z_vec;
            r_rd_idx    <= '0;
            r_out_valid <= 1'b1;
            r_state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (r_rd_idx == IXW'(NOUT-1)) begin
              r_rd_idx    <= '0;
              r_out_valid <= 1'b0;
              r_in_ready  <= 1'b1;
              r_state     <= S_LOAD;
            end else begin
              r_rd_idx <= r_rd_idx + 1'b1;
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign w_res     = r_res[r_rd_idx];
  assign x_vec     = r_x;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_idx   = r_rd_idx;
  assign out_last  = r_out_valid && (r_rd_idx == IXW'(NOUT-1));
  assign busy      = !((r_state == S_LOAD) && (r_wr_cnt == '0));

`ifdef FC_SEQ_REQUANT_EN
  localparam logic [OW-1:0] MAXV = {{(OW-WIDTH){1'b0}}, {WIDTH{1'b1}}};
  assign out_data = (w_res > MAXV) ? MAXV : w_res;
`else
  assign out_data = w_res;
`endif

endmodule

// File: tb/tb_fc_layer_seq.sv
// tb_fc_layer_seq: directed bench for fc_layer_seq.
// The neuron array is modelled as z[j] = x[2j] + x[2j+1], so each captured
// result is easy to derive by hand from the loaded vector.
module tb_fc_layer_seq;
  localparam int WIDTH  = 8;
  localparam int IN     = 128;
  localparam int NOUT   = 10;
  localparam int OW     = 23;
  localparam int SETTLE = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    clear;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        in_data;
  logic [WIDTH*IN-1:0]     x_vec;
  logic [OW*NOUT-1:0]      z_vec;
  logic                    out_valid;
  logic                    out_ready;
  logic [OW-1:0]           out_data;
  logic [$clog2(NOUT)-1:0] out_idx;
  logic                    out_last;
  logic                    busy;

  int errs   = 0;
  int checks = 0;
  logic [WIDTH-1:0] vec [IN];
  logic [31:0]      exp_z [NOUT];

  always #5 clk = ~clk;

  fc_layer_seq #(.WIDTH(WIDTH), .IN(IN), .NOUT(NOUT), .OW(OW), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .x_vec(x_vec), .z_vec(z_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  always_comb begin
    z_vec = '0;
    for (int j = 0; j < NOUT; j++)
      z_vec[j*OW +: OW] = OW'(x_vec[2*j*WIDTH +: WIDTH]) + OW'(x_vec[(2*j+1)*WIDTH +: WIDTH]);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_exp();
    for (int j = 0; j < NOUT; j++) begin
      exp_z[j] = 32'(vec[2*j]) + 32'(vec[2*j+1]);
`ifdef FC_SEQ_REQUANT_EN
      if (exp_z[j] > 255) exp_z[j] = 255;
`endif
    end
  endtask

  // Leaves in_valid high after the final beat so the bench can confirm it is ignored.
  task automatic load(input bit gap);
    for (int i = 0; i < IN; i++) begin
      if (i == IN-1) chk("pre_last_rdy", in_ready, 1);
      in_valid = 1'b1;
      in_data  = vec[i];
      @(posedge clk); #1;
      if (gap && i < IN-1) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    chk("post_last_rdy", in_ready, 0);
    chk("settle_busy", busy, 1);
  endtask

  // Called just after the final-beat edge; that edge counts as cycle 1.
  task automatic wait_ov(output int lat);
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ov_seen", out_valid, 1);
  endtask

  task automatic drain(input bit toggle);
    int e = 0;
    int c = 0;
    while (e < NOUT && c < 200) begin
      out_ready = toggle ? ~c[0] : 1'b1;
      if (out_valid) begin
        chk("d_idx", 32'(out_idx), e);
        chk("d_data", 32'(out_data), exp_z[e]);
        chk("d_last", out_last, 32'(e == NOUT-1));
        if (out_ready) e++;
      end else begin
        chk("d_valid", out_valid, 1);
      end
      @(posedge clk); #1;
      c++;
    end
    out_ready = 1'b0;
    chk("d_count", e, NOUT);
    chk("d_in_ready", in_ready, 1);
    chk("d_busy", busy, 0);
    chk("d_ovalid", out_valid, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_ovalid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_idx", 32'(out_idx), 0);
    chk("rst_last", out_last, 0);
    chk("rst_xvec", 32'(x_vec == '0), 1);
    #8 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    // Streaming load, in_valid held high, then drain with 1,0,1,0 backpressure
    for (int i = 0; i < IN; i++) vec[i] = 8'(i);
    set_exp();
    load(1'b0);
    chk("x5", 32'(x_vec[5*WIDTH +: WIDTH]), 5);
    chk("x127", 32'(x_vec[127*WIDTH +: WIDTH]), 127);
    wait_ov(lat);
    chk("latency_stream", lat, 3);
    in_valid = 1'b0;
    drain(1'b1);

    // Gapped input: in_valid low every other cycle
    for (int i = 0; i < IN; i++) vec[i] = 8'(i*3);
    set_exp();
    load(1'b1);
    in_valid = 1'b0;
    chk("x5_gap", 32'(x_vec[5*WIDTH +: WIDTH]), 15);
    wait_ov(lat);
    chk("latency_gap", lat, 3);
    drain(1'b0);

    // Clear during DRAIN at rd_idx=4 with out_ready=1
    for (int i = 0; i < IN; i++) vec[i] = 8'(i);
    set_exp();
    load(1'b0);
    in_valid = 1'b0;
    wait_ov(lat);
    out_ready = 1'b1;
    for (int k = 0; k < 20 && out_idx != 4; k++) begin
      @(posedge clk); #1;
    end
    chk("clr_at_idx", 32'(out_idx), 4);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    out_ready = 1'b0;
    chk("clr_ovalid", out_valid, 0);
    chk("clr_in_ready", in_ready, 1);
    chk("clr_busy", busy, 0);
    chk("clr_idx", 32'(out_idx), 0);
    chk("clr_x5_kept", 32'(x_vec[5*WIDTH +: WIDTH]), 5);
    repeat (3) @(posedge clk);
    #1;
    chk("clr_no_beat", out_valid, 0);

    // Reset pulsed during SETTLE
    load(1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ovalid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", 32'(out_data), 0);
    chk("mid_rst_x5", 32'(x_vec[5*WIDTH +: WIDTH]), 0);
    #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_rst_no_emit", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);

    // Requant vector: neuron 0 = 300, neuron 1 = 0, neuron 2 = 77
    for (int i = 0; i < IN; i++) vec[i] = 8'(i);
    vec[0] = 8'd150; vec[1] = 8'd150;
    vec[2] = 8'd0;   vec[3] = 8'd0;
    vec[4] = 8'd77;  vec[5] = 8'd0;
    set_exp();
`ifdef FC_SEQ_REQUANT_EN
    exp_z[0] = 255;
`else
    exp_z[0] = 300;
`endif
    exp_z[1] = 0;
    exp_z[2] = 77;
    load(1'b0);
    in_valid = 1'b0;
    wait_ov(lat);
    chk("latency_after_rst", lat, 3);
    drain(1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
